// File: rtl/echo_delay_pkg.sv
// Shared types and sample-arithmetic helpers for the echo/delay stage.
package echo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    MIX   = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam int SAMPLE_W = 16;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  // Clamp a 17-bit two's-complement sum into the 16-bit sample range.
  function automatic logic signed [SAMPLE_W-1:0] sat17to16(input logic signed [SAMPLE_W:0] s);
    if (s[SAMPLE_W] != s[SAMPLE_W-1]) begin
      return s[SAMPLE_W] ? SAT_MIN : SAT_MAX;
    end
    return s[SAMPLE_W-1:0];
  endfunction

  // Feedback attenuation: 0 -> /2, 1 -> /4, 2 -> /8, 3 -> muted.
  function automatic logic signed [SAMPLE_W-1:0] decay_shift(input logic [1:0] sel,
                                                             input logic signed [SAMPLE_W-1:0] x);
    case (sel)
      2'd0:    return x >>> 1;
      2'd1:    return x >>> 2;
      2'd2:    return x >>> 3;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// Single-port synchronous sample buffer with one-cycle registered read.
module echo_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Block-RAM style port: optional write, registered read-first data.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/echo_delay.sv
// Echo/delay stage: mixes each sample with a decayed copy from a circular
// buffer and writes the mix back, giving repeating, decaying echoes.
module echo_delay
  import echo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Sample_valid,
  input  logic signed [DATA_W-1:0] Data_in,
  input  logic                     Enable,
  input  logic [3:0]               Delay_sel,
  input  logic [1:0]               Decay_sel,
  output logic signed [DATA_W-1:0] Data_out,
  output logic                     Out_valid,
  output logic                     Busy,
  output logic                     Overrun
);

  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0] FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t                     state_q;
  logic signed [DATA_W-1:0]   in_q;
  logic                       en_q;
  logic [3:0]                 dsel_q;
  logic [1:0]                 dec_q;
  logic [ADDR_W-1:0]          wr_ptr_q;
  logic [ADDR_W:0]            fill_cnt_q;
  logic signed [DATA_W-1:0]   data_out_q;
  logic                       out_valid_q;
  logic                       busy_q;
  logic                       overrun_q;

  logic [ADDR_W:0]            delay_d;
  logic [ADDR_W-1:0]          rd_addr_d;
  logic signed [DATA_W-1:0]   echo_d;
  logic signed [DATA_W:0]     sum_d;
  logic signed [DATA_W-1:0]   mix_d;
  logic                       ram_we;
  logic [ADDR_W-1:0]          ram_addr;
  logic [DATA_W-1:0]          ram_rdata;

  // Delay length, read address, gated echo and saturated mix.
  always_comb begin
    delay_d   = AW1'({1'b0, dsel_q} + 5'd1) << (ADDR_W - 4);
    rd_addr_d = wr_ptr_q - delay_d[ADDR_W-1:0];
    echo_d    = '0;
    if (en_q && (dec_q != 2'd3) && (fill_cnt_q >= delay_d)) begin
      echo_d = decay_shift(dec_q, ram_rdata);
    end
    sum_d    = {in_q[DATA_W-1], in_q} + {echo_d[DATA_W-1], echo_d};
    mix_d    = sat17to16(sum_d);
    ram_we   = (state_q == WRITE);
    ram_addr = (state_q == WRITE) ? wr_ptr_q : rd_addr_d;
  end

  echo_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i  (Clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(data_out_q),
    .rdata_o(ram_rdata)
  );

  // Sequencer with registered outputs; reset abandons any in-flight write.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      in_q        <= '0;
      en_q        <= 1'b0;
      dsel_q      <= '0;
      dec_q       <= '0;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (Sample_valid && busy_q) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (Sample_valid) begin
            in_q    <= Data_in;
            en_q    <= Enable;
            dsel_q  <= Delay_sel;
            dec_q   <= Decay_sel;
            busy_q  <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          state_q <= MIX;
        end
        MIX: begin
          data_out_q  <= mix_d;
          out_valid_q <= 1'b1;
          state_q     <= WRITE;
        end
        WRITE: begin
          wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
          if (fill_cnt_q != FILL_MAX) begin
            fill_cnt_q <= fill_cnt_q + AW1'(1);
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Data_out  = data_out_q;
  assign Out_valid = out_valid_q;
  assign Busy      = busy_q;
  assign Overrun   = overrun_q;

endmodule

// File: tb/tb_echo_delay.sv
// Directed bench for echo_delay with a 64-sample buffer (delay unit = 4).
module tb_echo_delay;

  logic               Clk = 1'b0;
  logic               Reset_n;
  logic               Sample_valid;
  logic signed [15:0] Data_in;
  logic               Enable;
  logic [3:0]         Delay_sel;
  logic [1:0]         Decay_sel;
  logic signed [15:0] Data_out;
  logic               Out_valid;
  logic               Busy;
  logic               Overrun;

  int vec_cnt = 0;
  int err_cnt = 0;

  echo_delay #(
    .DATA_W(16),
    .ADDR_W(6)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Sample_valid(Sample_valid),
    .Data_in     (Data_in),
    .Enable      (Enable),
    .Delay_sel   (Delay_sel),
    .Decay_sel   (Decay_sel),
    .Data_out    (Data_out),
    .Out_valid   (Out_valid),
    .Busy        (Busy),
    .Overrun     (Overrun)
  );

  always #5 Clk = ~Clk;

  task automatic do_reset();
    @(negedge Clk);
    Sample_valid = 1'b0;
    Reset_n      = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  // Pulse one sample and wait (bounded) for its Out_valid; lat counts cycles.
  task automatic send(input logic signed [15:0] d, output logic signed [15:0] q, output int lat);
    @(negedge Clk);
    Sample_valid = 1'b1;
    Data_in      = d;
    @(negedge Clk);
    Sample_valid = 1'b0;
    lat = 1;
    while (!Out_valid && lat < 10) begin
      @(negedge Clk);
      lat++;
    end
    q = Data_out;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    vec_cnt++; if (Data_out !== 16'sh0000) begin err_cnt++; $display("FAIL reset_data_out got %h want 0000", Data_out); end
    vec_cnt++; if (Out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid got %b want 0", Out_valid); end
    vec_cnt++; if (Busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", Busy); end
    vec_cnt++; if (Overrun !== 1'b0) begin err_cnt++; $display("FAIL reset_overrun got %b want 0", Overrun); end
    vec_cnt++; if (dut.wr_ptr_q !== 6'd0) begin err_cnt++; $display("FAIL reset_wr_ptr got %0d want 0", dut.wr_ptr_q); end
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_impulse();
    logic signed [15:0] q, want;
    int lat;
    do_reset();
    Enable = 1'b1; Delay_sel = 4'd0; Decay_sel = 2'd0;
    for (int i = 0; i < 17; i++) begin
      send((i == 0) ? 16'sh4000 : 16'sh0000, q, lat);
      want = '0;
      if (i % 4 == 0) want = 16'sh4000 >>> (i / 4);
      vec_cnt++; if (lat !== 3) begin err_cnt++; $display("FAIL impulse_latency idx %0d got %0d want 3", i, lat); end
      vec_cnt++; if (q !== want) begin err_cnt++; $display("FAIL impulse idx %0d got %h want %h", i, q, want); end
    end
  endtask

  task automatic test_decay();
    logic signed [15:0] imp  [4] = '{16'sh4000, 16'sh4000, 16'sh4000, 16'shC000};
    logic [1:0]         dsel [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic signed [15:0] want [4] = '{16'sh1000, 16'sh0800, 16'sh0000, 16'shE000};
    logic signed [15:0] q;
    int lat;
    for (int c = 0; c < 4; c++) begin
      do_reset();
      Enable = 1'b1; Delay_sel = 4'd0; Decay_sel = dsel[c];
      for (int i = 0; i < 5; i++) begin
        send((i == 0) ? imp[c] : 16'sh0000, q, lat);
        if (i == 0) begin
          vec_cnt++; if (q !== imp[c]) begin err_cnt++; $display("FAIL decay_dry case %0d got %h want %h", c, q, imp[c]); end
        end
      end
      vec_cnt++; if (q !== want[c]) begin err_cnt++; $display("FAIL decay_echo case %0d got %h want %h", c, q, want[c]); end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] cval [2] = '{16'sh7000, 16'sh9000};
    logic signed [15:0] want [2] = '{16'sh7FFF, 16'sh8000};
    logic signed [15:0] q;
    int lat;
    for (int c = 0; c < 2; c++) begin
      do_reset();
      Enable = 1'b1; Delay_sel = 4'd0; Decay_sel = 2'd0;
      for (int i = 0; i < 5; i++) begin
        send(cval[c], q, lat);
        if (i == 3) begin
          vec_cnt++; if (q !== cval[c]) begin err_cnt++; $display("FAIL sat_pre case %0d got %h want %h", c, q, cval[c]); end
        end
      end
      vec_cnt++; if (q !== want[c]) begin err_cnt++; $display("FAIL sat_clip case %0d got %h want %h", c, q, want[c]); end
    end
  endtask

  task automatic test_fill_gating();
    logic signed [15:0] q, want;
    int lat;
    // Fill the whole buffer with 0x1111 through bypass, then reset.
    do_reset();
    Enable = 1'b0; Delay_sel = 4'd0; Decay_sel = 2'd0;
    for (int i = 0; i < 64; i++) send(16'sh1111, q, lat);
    vec_cnt++; if (q !== 16'sh1111) begin err_cnt++; $display("FAIL preload got %h want 1111", q); end
    do_reset();
    Enable = 1'b1; Delay_sel = 4'd1; Decay_sel = 2'd0;
    for (int i = 0; i < 19; i++) begin
      send((i == 10) ? 16'sh0400 : 16'sh0000, q, lat);
      want = (i == 10) ? 16'sh0400 : (i == 18) ? 16'sh0200 : 16'sh0000;
      vec_cnt++; if (q !== want) begin err_cnt++; $display("FAIL fill_gate idx %0d got %h want %h", i, q, want); end
    end
  endtask

  task automatic test_bypass();
    logic signed [15:0] q, want;
    int lat;
    do_reset();
    Enable = 1'b0; Delay_sel = 4'd0; Decay_sel = 2'd0;
    for (int i = 0; i < 12; i++) begin
      if (i == 8) Enable = 1'b1;
      send(16'(i + 1), q, lat);
      want = (i < 8) ? 16'(i + 1) : 16'((i + 1) + (i - 3) / 2);
      vec_cnt++; if (lat !== 3) begin err_cnt++; $display("FAIL bypass_latency idx %0d got %0d want 3", i, lat); end
      vec_cnt++; if (q !== want) begin err_cnt++; $display("FAIL bypass idx %0d got %h want %h", i, q, want); end
    end
  endtask

  task automatic test_overrun();
    logic signed [15:0] q;
    int lat, pulses;
    do_reset();
    Enable = 1'b1; Delay_sel = 4'd0; Decay_sel = 2'd0;
    @(negedge Clk); Sample_valid = 1'b1; Data_in = 16'sh0100;
    @(negedge Clk); Sample_valid = 1'b0;
    @(negedge Clk); Sample_valid = 1'b1; Data_in = 16'sh0200;
    @(negedge Clk); Sample_valid = 1'b0;
    vec_cnt++; if (Out_valid !== 1'b1) begin err_cnt++; $display("FAIL ovr_out_valid got %b want 1", Out_valid); end
    vec_cnt++; if (Data_out !== 16'sh0100) begin err_cnt++; $display("FAIL ovr_data got %h want 0100", Data_out); end
    vec_cnt++; if (Overrun !== 1'b1) begin err_cnt++; $display("FAIL ovr_flag got %b want 1", Overrun); end
    pulses = 0;
    repeat (8) begin
      @(negedge Clk);
      if (Out_valid) pulses++;
    end
    vec_cnt++; if (pulses !== 0) begin err_cnt++; $display("FAIL ovr_extra_pulses got %0d want 0", pulses); end
    vec_cnt++; if (dut.wr_ptr_q !== 6'd1) begin err_cnt++; $display("FAIL ovr_wr_ptr got %0d want 1", dut.wr_ptr_q); end
    send(16'sh0300, q, lat);
    vec_cnt++; if (q !== 16'sh0300) begin err_cnt++; $display("FAIL ovr_next got %h want 0300", q); end
    vec_cnt++; if (Overrun !== 1'b1) begin err_cnt++; $display("FAIL ovr_sticky got %b want 1", Overrun); end
  endtask

  task automatic test_reset_midop();
    logic signed [15:0] q;
    int lat, pulses;
    do_reset();
    Enable = 1'b1; Delay_sel = 4'd0; Decay_sel = 2'd0;
    send(16'sh0011, q, lat);
    send(16'sh0022, q, lat);
    @(negedge Clk); Sample_valid = 1'b1; Data_in = 16'sh1234;
    @(negedge Clk); Sample_valid = 1'b0;
    @(negedge Clk);
    vec_cnt++; if (Busy !== 1'b1) begin err_cnt++; $display("FAIL midop_busy got %b want 1", Busy); end
    vec_cnt++; if (Data_out !== 16'sh0022) begin err_cnt++; $display("FAIL midop_pre got %h want 0022", Data_out); end
    Reset_n = 1'b0;
    #1;
    vec_cnt++; if (Data_out !== 16'sh0000) begin err_cnt++; $display("FAIL midop_data got %h want 0000", Data_out); end
    vec_cnt++; if (Busy !== 1'b0) begin err_cnt++; $display("FAIL midop_busy_rst got %b want 0", Busy); end
    vec_cnt++; if (dut.wr_ptr_q !== 6'd0) begin err_cnt++; $display("FAIL midop_wr_ptr got %0d want 0", dut.wr_ptr_q); end
    pulses = 0;
    repeat (4) begin
      @(negedge Clk);
      if (Out_valid) pulses++;
    end
    vec_cnt++; if (pulses !== 0) begin err_cnt++; $display("FAIL midop_pulses got %0d want 0", pulses); end
    Reset_n = 1'b1;
    send(16'sh0050, q, lat);
    vec_cnt++; if (lat !== 3) begin err_cnt++; $display("FAIL midop_after_latency got %0d want 3", lat); end
    vec_cnt++; if (q !== 16'sh0050) begin err_cnt++; $display("FAIL midop_after got %h want 0050", q); end
    @(negedge Clk);
    vec_cnt++; if (dut.wr_ptr_q !== 6'd1) begin err_cnt++; $display("FAIL midop_after_ptr got %0d want 1", dut.wr_ptr_q); end
  endtask

  task automatic test_wrap();
    int y [70];
    int xv, e, s, lat;
    logic signed [15:0] q;
    do_reset();
    Enable = 1'b1; Delay_sel = 4'd0; Decay_sel = 2'd0;
    for (int k = 0; k < 70; k++) begin
      xv = ((k * 1237) % 8192) - 4096;
      e  = (k >= 4) ? (y[k-4] >>> 1) : 0;
      s  = xv + e;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      y[k] = s;
      send(16'(xv), q, lat);
      vec_cnt++; if (q !== 16'(s)) begin err_cnt++; $display("FAIL wrap idx %0d got %h want %h", k, q, 16'(s)); end
      if (k == 63) begin
        vec_cnt++; if (dut.wr_ptr_q !== 6'd63) begin err_cnt++; $display("FAIL wrap_ptr63 got %0d want 63", dut.wr_ptr_q); end
      end
    end
    @(negedge Clk);
    vec_cnt++; if (dut.wr_ptr_q !== 6'd6) begin err_cnt++; $display("FAIL wrap_ptr_end got %0d want 6", dut.wr_ptr_q); end
  endtask

  initial begin
    Reset_n      = 1'b1;
    Sample_valid = 1'b0;
    Data_in      = '0;
    Enable       = 1'b0;
    Delay_sel    = '0;
    Decay_sel    = '0;
    test_reset();
    test_impulse();
    test_decay();
    test_saturation();
    test_fill_gating();
    test_bypass();
    test_overrun();
    test_reset_midop();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
